// File: rtl/flag_gen_stage.sv
// EX-stage flag producer: S1 forms A+B or A-B with carry, S2 derives Zero/Less/Overflow.
// Two-entry elastic pipeline with valid/ready handshake, synchronous flush and async reset.
module flag_gen_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             AluSub,
   input  logic             Signed,
   input  logic             V_in,
   input  logic [2:0]       Condition_in,
   input  logic             Branch_in,
   input  logic             RegWrite_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Less,
   output logic             Overflow,
   output logic             V,
   output logic [2:0]       Condition,
   output logic             Branch,
   output logic             RegWrite
);

   // S1 state
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH:0]   r_q, r_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic             sub_q, sub_d, sgn_q, sgn_d, v1_q, v1_d;
   logic [2:0]       cond1_q, cond1_d;
   logic             br1_q, br1_d, rw1_q, rw1_d;

   // S2 state (drives the outputs directly)
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, less_q, less_d, ovf_q, ovf_d, v2_q, v2_d;
   logic [2:0]       cond2_q, cond2_d;
   logic             br2_q, br2_d, rw2_q, rw2_d;

   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] res1;
   logic             ovf_s;

   assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s2_adv;
   assign s1_adv   = in_valid & in_ready;

   assign res1  = r_q[WIDTH-1:0];
   assign ovf_s = sub_q ? ((a_msb_q != b_msb_q) && (res1[WIDTH-1] != a_msb_q))
                        : ((a_msb_q == b_msb_q) && (res1[WIDTH-1] != a_msb_q));

   always_comb begin
      s1_valid_d = s1_valid_q;
      r_d        = r_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      sub_d      = sub_q;
      sgn_d      = sgn_q;
      v1_d       = v1_q;
      cond1_d    = cond1_q;
      br1_d      = br1_q;
      rw1_d      = rw1_q;
      if (s1_adv) begin
         s1_valid_d = 1'b1;
         r_d        = {1'b0, A} + {1'b0, (AluSub ? ~B : B)} + {{WIDTH{1'b0}}, AluSub};
         a_msb_d    = A[WIDTH-1];
         b_msb_d    = B[WIDTH-1];
         sub_d      = AluSub;
         sgn_d      = Signed;
         v1_d       = V_in;
         cond1_d    = Condition_in;
         br1_d      = Branch_in;
         rw1_d      = RegWrite_in;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end
      // Flush wins over any accept; stale data in the regs is harmless once invalid.
      if (flush) s1_valid_d = 1'b0;
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      zero_d     = zero_q;
      less_d     = less_q;
      ovf_d      = ovf_q;
      v2_d       = v2_q;
      cond2_d    = cond2_q;
      br2_d      = br2_q;
      rw2_d      = rw2_q;
      if (s2_adv) begin
         s2_valid_d = 1'b1;
         result_d   = res1;
         zero_d     = (res1 == '0);
         ovf_d      = sgn_q & ovf_s;
         less_d     = sub_q ? (sgn_q ? (res1[WIDTH-1] ^ ovf_s) : ~r_q[WIDTH]) : 1'b0;
         v2_d       = v1_q;
         cond2_d    = cond1_q;
         br2_d      = br1_q;
         rw2_d      = rw1_q;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
      if (flush) s2_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         r_q        <= '0;
         a_msb_q    <= 1'b0;
         b_msb_q    <= 1'b0;
         sub_q      <= 1'b0;
         sgn_q      <= 1'b0;
         v1_q       <= 1'b0;
         cond1_q    <= 3'd0;
         br1_q      <= 1'b0;
         rw1_q      <= 1'b0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         less_q     <= 1'b0;
         ovf_q      <= 1'b0;
         v2_q       <= 1'b0;
         cond2_q    <= 3'd0;
         br2_q      <= 1'b0;
         rw2_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         r_q        <= r_d;
         a_msb_q    <= a_msb_d;
         b_msb_q    <= b_msb_d;
         sub_q      <= sub_d;
         sgn_q      <= sgn_d;
         v1_q       <= v1_d;
         cond1_q    <= cond1_d;
         br1_q      <= br1_d;
         rw1_q      <= rw1_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         less_q     <= less_d;
         ovf_q      <= ovf_d;
         v2_q       <= v2_d;
         cond2_q    <= cond2_d;
         br2_q      <= br2_d;
         rw2_q      <= rw2_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign Result    = result_q;
   assign Zero      = zero_q;
   assign Less      = less_q;
   assign Overflow  = ovf_q;
   assign V         = v2_q;
   assign Condition = cond2_q;
   assign Branch    = br2_q;
   assign RegWrite  = rw2_q;

endmodule

// File: tb/tb_flag_gen_stage.sv
// Directed bench for flag_gen_stage: arithmetic flag vectors, backpressure stream, flush and reset.
module tb_flag_gen_stage;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready;
   logic [W-1:0]  A, B;
   logic          AluSub, Signed, V_in, Branch_in, RegWrite_in;
   logic [2:0]    Condition_in;
   logic          out_valid, out_ready;
   logic [W-1:0]  Result;
   logic          Zero, Less, Overflow, V, Branch, RegWrite;
   logic [2:0]    Condition;

   int n_assert = 0;
   int n_fail   = 0;

   flag_gen_stage #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .AluSub(AluSub), .Signed(Signed), .V_in(V_in),
      .Condition_in(Condition_in), .Branch_in(Branch_in), .RegWrite_in(RegWrite_in),
      .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Zero(Zero),
      .Less(Less), .Overflow(Overflow), .V(V), .Condition(Condition),
      .Branch(Branch), .RegWrite(RegWrite)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("assertion %s", tag);
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic sgn, input logic vin, input logic [2:0] cond);
      A = a; B = b; AluSub = sub; Signed = sgn; V_in = vin; Condition_in = cond;
      Branch_in = cond[0]; RegWrite_in = cond[1];
   endtask

   // Offer one op for a single cycle, then check latency and every output field.
   task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic sgn, input logic vin, input logic [2:0] cond,
                           input logic [W-1:0] e_res, input logic e_z, input logic e_l,
                           input logic e_o);
      drive(a, b, sub, sgn, vin, cond);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_res"}, {32'd0, Result}, {32'd0, e_res});
      chk({tag, "_flags"}, {60'd0, Zero, Less, Overflow, V}, {60'd0, e_z, e_l, e_o, vin});
      chk({tag, "_ctl"}, {59'd0, Condition, Branch, RegWrite}, {59'd0, cond, cond[0], cond[1]});
      $display("op %s: A=%h B=%h sub=%0d sgn=%0d -> R=%h Z=%0d L=%0d O=%0d", tag, a, b, sub, sgn,
               Result, Zero, Less, Overflow);
      @(negedge clk);
   endtask

   initial begin
      int acc, emit, cyc;
      logic [W-1:0] held;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive('0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_outputs", {25'd0, Result, Zero, Less, Overflow, V, Condition, Branch, RegWrite}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      op_check("sub_eq",     32'd5,          32'd5, 1, 1, 0, 3'd1, 32'd0,          1, 0, 0);
      op_check("sub_sovf",   32'h8000_0000,  32'd1, 1, 1, 1, 3'd5, 32'h7FFF_FFFF,  0, 1, 1);
      op_check("sub_ult",    32'd1,          32'd2, 1, 0, 0, 3'd5, 32'hFFFF_FFFF,  0, 1, 0);
      op_check("sub_slt",    32'd1,          32'd2, 1, 1, 0, 3'd6, 32'hFFFF_FFFF,  0, 1, 0);
      op_check("add_sovf",   32'h7FFF_FFFF,  32'd1, 0, 1, 0, 3'd3, 32'h8000_0000,  0, 0, 1);
      op_check("add_unsg",   32'h7FFF_FFFF,  32'd1, 0, 0, 0, 3'd4, 32'h8000_0000,  0, 0, 0);
      op_check("add_wrap",   32'hFFFF_FFFF,  32'd1, 0, 0, 0, 3'd7, 32'd0,          1, 0, 0);
      op_check("sub_uge",    32'd2,          32'd1, 1, 0, 0, 3'd2, 32'd1,          0, 0, 0);

      // Backpressure stream: 4 adds, out_ready low for the first 5 cycles.
      acc = 0; emit = 0; out_ready = 1'b0;
      for (cyc = 0; cyc < 30 && emit < 4; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (acc < 4);
         drive(100 * acc + 7, acc + 1, 1'b0, 1'b0, 1'b0, acc[2:0]);
         #1;
         if (cyc >= 2 && cyc <= 4) begin
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_accepted", acc, 64'd2);
            if (cyc == 2) held = Result;
            else chk("bp_stable", {32'd0, Result}, {32'd0, held});
         end
         if (out_valid && out_ready) begin
            chk("bp_res", {32'd0, Result}, 100 * emit + 7 + emit + 1);
            chk("bp_cond", {61'd0, Condition}, emit % 8);
            $display("stream out %0d: R=%0d cond=%0d", emit, Result, Condition);
            emit++;
         end
         if (in_valid && in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_count", emit, 64'd4);
      @(negedge clk);
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Flush with two entries in flight plus an offered input.
      out_ready = 1'b0;
      drive(32'd11, 32'd1, 0, 0, 0, 3'd1); in_valid = 1'b1; @(negedge clk);
      drive(32'd22, 32'd1, 0, 0, 0, 3'd2); @(negedge clk);
      chk("fl_full", {62'd0, out_valid, in_ready}, 64'b10);
      drive(32'd33, 32'd1, 0, 0, 0, 3'd3); flush = 1'b1; @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_empty", {62'd0, out_valid, in_ready}, 64'b01);
      out_ready = 1'b1;
      emit = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) emit++;
         @(negedge clk);
      end
      chk("fl_nothing", emit, 64'd0);
      $display("flush done");

      // Async reset pulse mid-stream.
      drive(32'd44, 32'd4, 1, 1, 1, 3'd7); in_valid = 1'b1; @(negedge clk);
      @(negedge clk);
      chk("rs_pre", {63'd0, out_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_async", {24'd0, out_valid, Result, Zero, Less, Overflow, V, Condition, Branch, RegWrite}, 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rs_after", {62'd0, out_valid, in_ready}, 64'b01);
      $display("reset pulse done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
